// File: rtl/arbitro_mult_div_if.sv
// rtl/arbitro_mult_div_if.sv - signal bundle between two requesters, the mult/div arbiter and the unit
//
// Groups every non-clock signal of arbitro_mult_div.
//   Requester side : req0/op0/a0/b0, req1/op1/a1/b1 into the arbiter;
//                    ack0/ack1/res/err back to the requesters.
//   Unit side      : go/div_mult/ent_32/ent_16 to the unit; sal_32/done from it.
// Modports: master = the arbiter view, slave = the surrounding environment view.
interface arbitro_mult_div_if #(
    parameter int ANCHO_A = 32,
    parameter int ANCHO_B = 16
);
    logic               req0;
    logic               op0;
    logic [ANCHO_A-1:0] a0;
    logic [ANCHO_B-1:0] b0;
    logic               req1;
    logic               op1;
    logic [ANCHO_A-1:0] a1;
    logic [ANCHO_B-1:0] b1;
    logic               ack0;
    logic               ack1;
    logic [ANCHO_A-1:0] res;
    logic               err;
    logic               go;
    logic               div_mult;
    logic [ANCHO_A-1:0] ent_32;
    logic [ANCHO_B-1:0] ent_16;
    logic [ANCHO_A-1:0] sal_32;
    logic               done;

    modport master (
        input  req0, op0, a0, b0, req1, op1, a1, b1, sal_32, done,
        output ack0, ack1, res, err, go, div_mult, ent_32, ent_16
    );

    modport slave (
        output req0, op0, a0, b0, req1, op1, a1, b1, sal_32, done,
        input  ack0, ack1, res, err, go, div_mult, ent_32, ent_16
    );
endinterface

// File: rtl/arbitro_mult_div.sv
// rtl/arbitro_mult_div.sv - round-robin arbiter/sequencer sharing one mult/div unit between two requesters
//
// Ports:
//   reloj  - system clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - arbitro_mult_div_if.master: requester handshakes (req/op/a/b in,
//            ack/res/err out) and unit handshake (go/div_mult/ent_32/ent_16 out,
//            sal_32/done in). Every output is a register.
// Flow: REPOSO -> LANZA -> ESPERA -> ENTREGA -> LIBERA -> REPOSO.
// A watchdog ends ESPERA with err=1 after TMO_CICLOS cycles without done.
module arbitro_mult_div #(
    parameter int ANCHO_A    = 32,
    parameter int ANCHO_B    = 16,
    parameter int TMO_CICLOS = 200
) (
    input  logic               reloj,
    input  logic               reset,
    arbitro_mult_div_if.master bus
);
    // wd holds the number of ESPERA cycles already completed, so the
    // TMO_CICLOS-th ESPERA edge sees TMO_CICLOS-1.
    localparam logic [7:0] WD_ULTIMO = 8'(TMO_CICLOS - 1);

    typedef enum logic [2:0] {
        REPOSO,
        LANZA,
        ESPERA,
        ENTREGA,
        LIBERA
    } estado_t;

    estado_t            estado;
    logic [7:0]         wd;
    logic               puntero;     // requester favoured when both ask
    logic               id;          // requester currently being served
    logic               go_q;
    logic               ack0_q;
    logic               ack1_q;
    logic               err_q;
    logic               div_mult_q;
    logic [ANCHO_A-1:0] res_q;
    logic [ANCHO_A-1:0] ent_32_q;
    logic [ANCHO_B-1:0] ent_16_q;
    logic               elige_1;

    // Requester 1 wins when it is alone or when both ask and the pointer favours it.
    assign elige_1 = bus.req1 && (!bus.req0 || puntero);

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            estado     <= REPOSO;
            wd         <= '0;
            puntero    <= 1'b0;
            id         <= 1'b0;
            go_q       <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err_q      <= 1'b0;
            div_mult_q <= 1'b0;
            res_q      <= '0;
            ent_32_q   <= '0;
            ent_16_q   <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (bus.req0 || bus.req1) begin
                        id         <= elige_1;
                        div_mult_q <= elige_1 ? bus.op1 : bus.op0;
                        ent_32_q   <= elige_1 ? bus.a1  : bus.a0;
                        ent_16_q   <= elige_1 ? bus.b1  : bus.b0;
                        estado     <= LANZA;
                    end
                end
                LANZA: begin
                    go_q   <= 1'b1;
                    wd     <= '0;
                    estado <= ESPERA;
                end
                ESPERA: begin
                    // done has priority over a timeout on the same edge
                    if (bus.done) begin
                        res_q  <= bus.sal_32;
                        err_q  <= 1'b0;
                        go_q   <= 1'b0;
                        ack0_q <= !id;
                        ack1_q <= id;
                        estado <= ENTREGA;
                    end else if (wd == WD_ULTIMO) begin
                        res_q  <= '0;
                        err_q  <= 1'b1;
                        go_q   <= 1'b0;
                        ack0_q <= !id;
                        ack1_q <= id;
                        estado <= ENTREGA;
                    end else begin
                        wd <= wd + 8'd1;
                    end
                end
                ENTREGA: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    puntero <= !id;
                    estado  <= LIBERA;
                end
                LIBERA: begin
                    // a unit that never releases done keeps the arbiter parked here
                    if (!bus.done) begin
                        estado <= REPOSO;
                    end
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

    assign bus.go       = go_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.err      = err_q;
    assign bus.res      = res_q;
    assign bus.div_mult = div_mult_q;
    assign bus.ent_32   = ent_32_q;
    assign bus.ent_16   = ent_16_q;
endmodule

// File: tb/tb_arbitro_mult_div.sv
// tb/tb_arbitro_mult_div.sv - self-checking bench for arbitro_mult_div
module tb_arbitro_mult_div;
    localparam int A   = 32;
    localparam int B   = 16;
    localparam int TMO = 200;

    logic reloj = 1'b0;
    logic reset = 1'b1;
    always #5 reloj = ~reloj;

    arbitro_mult_div_if #(.ANCHO_A(A), .ANCHO_B(B)) bus ();

    arbitro_mult_div #(.ANCHO_A(A), .ANCHO_B(B), .TMO_CICLOS(TMO)) dut (
        .reloj (reloj),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // requester state
    logic        req [2];
    logic        op  [2];
    logic [31:0] a   [2];
    logic [15:0] b   [2];
    logic        fop [2];
    logic [31:0] fa  [2];
    logic [15:0] fb  [2];
    int          pend [2];
    bit          drop_next [2];
    bit          cool [2];
    int          raise_cyc [2];
    bit          rand_ops  = 0;
    int          raise_pct = 100;

    // unit model
    bit          stuck = 0;
    bit          rand_unit = 0;
    int          lat  = 2;
    int          hold = 0;
    bit          u_busy = 0;
    bit          u_done = 0;
    int          u_cnt  = 0;
    int          u_hold_n = 0;
    logic [31:0] u_sal = '0;

    // reference model (spec-level phases: idle, granted, running, delivering, releasing)
    int          ph  = 0;
    bit          ptr = 0;
    int          win = 0;
    logic        eop;
    logic [31:0] ea;
    logic [15:0] eb;
    int          n_run = 0;
    logic [31:0] e_res;
    logic        e_err;
    logic        e_ack0, e_ack1;

    // event log for hand-computed expectations
    int          ack_log[$];
    logic [31:0] last_res;
    logic        last_err;
    int          go_cnt = 0;
    int          last_go_cnt = 0;
    bit          go_prev = 0;
    int          go_rise_cyc = 0;
    int          last_done_cyc = 0;
    int          last_gap = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ideal(logic d, logic [31:0] x, logic [15:0] y);
        logic [31:0] yy;
        yy = {16'd0, y};
        return d ? x / yy : x * yy;
    endfunction

    task automatic apply();
        bus.req0 = req[0]; bus.op0 = op[0]; bus.a0 = a[0]; bus.b0 = b[0];
        bus.req1 = req[1]; bus.op1 = op[1]; bus.a1 = a[1]; bus.b1 = b[1];
        bus.done = u_done; bus.sal_32 = u_sal;
    endtask

    // Inputs still on the bus are those the last edge sampled; outputs reflect that edge.
    task automatic check();
        e_ack0 = 1'b0;
        e_ack1 = 1'b0;
        case (ph)
            0: if (bus.req0 || bus.req1) begin
                   win = (bus.req0 && bus.req1) ? int'(ptr) : (bus.req1 ? 1 : 0);
                   eop = (win == 1) ? bus.op1 : bus.op0;
                   ea  = (win == 1) ? bus.a1  : bus.a0;
                   eb  = (win == 1) ? bus.b1  : bus.b0;
                   ph  = 1;
               end
            1: begin ph = 2; n_run = 0; end
            2: begin
                   n_run++;
                   if (bus.done) begin
                       e_res = ideal(eop, ea, eb); e_err = 1'b0; ph = 3;
                   end else if (n_run == TMO) begin
                       e_res = '0; e_err = 1'b1; ph = 3;
                   end
                   if (ph == 3) begin
                       e_ack0 = (win == 0);
                       e_ack1 = (win == 1);
                   end
               end
            3: begin ptr = (win == 0); ph = 4; end
            default: if (!bus.done) ph = 0;
        endcase

        chk("go", bus.go, (ph == 2));
        chk("ack0", bus.ack0, e_ack0);
        chk("ack1", bus.ack1, e_ack1);
        if (e_ack0 || e_ack1) begin
            chk("res", bus.res, e_res);
            chk("err", bus.err, e_err);
        end
        if (ph == 2) begin
            chk("div_mult", bus.div_mult, eop);
            chk("ent_32", bus.ent_32, ea);
            chk("ent_16", bus.ent_16, eb);
        end

        if (bus.ack0 || bus.ack1) begin
            ack_log.push_back(bus.ack1 ? 1 : 0);
            last_res = bus.res;
            last_err = bus.err;
            last_go_cnt = go_cnt;
        end
        if (bus.go) begin
            if (!go_prev) begin
                go_cnt = 0;
                last_gap = cyc - last_done_cyc;
                go_rise_cyc = cyc;
            end
            go_cnt++;
        end
        go_prev = bus.go;
        if (bus.done) last_done_cyc = cyc;
    endtask

    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            if (drop_next[r]) begin
                req[r] = 1'b0; drop_next[r] = 0; cool[r] = 1;
            end else if ((r == 0) ? bus.ack0 : bus.ack1) begin
                drop_next[r] = 1;
            end else if (!req[r] && pend[r] > 0) begin
                if (cool[r]) cool[r] = 0;
                else if ($urandom_range(0, 99) < raise_pct) begin
                    req[r] = 1'b1;
                    pend[r]--;
                    raise_cyc[r] = cyc;
                    if (rand_ops) begin
                        op[r] = 1'($urandom_range(0, 1));
                        a[r]  = $urandom;
                        b[r]  = 16'($urandom_range(1, 65535));
                    end else begin
                        op[r] = fop[r]; a[r] = fa[r]; b[r] = fb[r];
                    end
                end
            end
        end
        if (stuck) begin
            u_done = 0; u_busy = 0;
        end else begin
            if (!u_busy && !u_done && bus.go) begin
                u_busy = 1;
                u_cnt  = rand_unit ? $urandom_range(0, 6) : lat;
                u_sal  = ideal(bus.div_mult, bus.ent_32, bus.ent_16);
            end
            if (u_busy) begin
                if (u_cnt == 0) begin
                    u_busy = 0; u_done = 1;
                    u_hold_n = rand_unit ? $urandom_range(0, 3) : hold;
                end else u_cnt--;
            end else if (u_done && !bus.go) begin
                if (u_hold_n == 0) u_done = 0;
                else u_hold_n--;
            end
        end
        apply();
    endtask

    task automatic step();
        @(negedge reloj);
        cyc++;
        check();
        drive();
    endtask

    task automatic clear_env();
        ph = 0; ptr = 0; go_prev = 0;
        u_busy = 0; u_done = 0;
        for (int r = 0; r < 2; r++) begin
            req[r] = 0; op[r] = 0; a[r] = '0; b[r] = '0;
            pend[r] = 0; drop_next[r] = 0; cool[r] = 0;
        end
        apply();
    endtask

    task automatic do_reset(bit check_lit);
        @(negedge reloj);
        #2 reset = 1'b0;
        #1;
        if (check_lit) begin
            chk("rst_go", bus.go, 0);
            chk("rst_ack0", bus.ack0, 0);
            chk("rst_ack1", bus.ack1, 0);
            chk("rst_err", bus.err, 0);
        end
        clear_env();
        @(negedge reloj);
        reset = 1'b1;
    endtask

    task automatic run_acks(int n, int limit, string name);
        int got = 0;
        int c = 0;
        while (got < n && c < limit) begin
            step();
            c++;
            if (bus.ack0 || bus.ack1) got++;
        end
        tests++;
        if (got < n) begin
            fails++;
            $display("FAIL %s: only %0d of %0d acks within %0d cycles", name, got, n, limit);
        end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic wait_go(int limit, string name);
        int c = 0;
        while (!bus.go && c < limit) begin step(); c++; end
        tests++;
        if (!bus.go) begin
            fails++;
            $display("FAIL %s: go not seen within %0d cycles", name, limit);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};
        clear_env();
        #1 reset = 1'b0;
        #2;
        chk("reset_go", bus.go, 0);
        chk("reset_ack0", bus.ack0, 0);
        chk("reset_ack1", bus.ack1, 0);
        chk("reset_err", bus.err, 0);
        chk("reset_div_mult", bus.div_mult, 0);
        chk("reset_res", bus.res, 0);
        chk("reset_ent_32", bus.ent_32, 0);
        chk("reset_ent_16", bus.ent_16, 0);
        @(negedge reloj);
        @(negedge reloj);
        reset = 1'b1;

        // single multiply from requester 0
        lat = 2; hold = 0; stuck = 0; rand_ops = 0; raise_pct = 100;
        fop[0] = 0; fa[0] = 1000; fb[0] = 25;
        ack_log.delete();
        pend[0] = 1;
        run_acks(1, 60, "t1_ack");
        chk("t1_go_delay", go_rise_cyc - raise_cyc[0], 2);
        chk("t1_nacks", ack_log.size(), 1);
        chk("t1_who", (ack_log.size() > 0) ? ack_log[0] : -1, 0);
        chk("t1_res", last_res, 25000);
        chk("t1_err", last_err, 0);

        // single divide from requester 1
        fop[1] = 1; fa[1] = 100000; fb[1] = 7;
        ack_log.delete();
        pend[1] = 1;
        run_acks(1, 60, "t2_ack");
        chk("t2_who", (ack_log.size() > 0) ? ack_log[0] : -1, 1);
        chk("t2_res", last_res, 14285);
        chk("t2_err", last_err, 0);

        // both requesters hammering: strict alternation starting at 0
        do_reset(0);
        fop[0] = 0; fa[0] = 3;   fb[0] = 4;
        fop[1] = 1; fa[1] = 999; fb[1] = 9;
        ack_log.delete();
        pend[0] = 2; pend[1] = 2;
        run_acks(4, 200, "t3_acks");
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_order%0d", i), (ack_log.size() > i) ? ack_log[i] : -1, exp_order[i]);

        // unit never answers: watchdog, then normal service
        stuck = 1;
        ack_log.delete();
        pend[0] = 1;
        run_acks(1, 400, "t4_tmo_ack");
        chk("t4_go_cycles", last_go_cnt, TMO);
        chk("t4_err", last_err, 1);
        chk("t4_res", last_res, 0);
        stuck = 0;
        pend[1] = 1;
        run_acks(1, 60, "t4_after");
        chk("t4_after_err", last_err, 0);
        chk("t4_after_res", last_res, 111);

        // unit keeps done high for a while: pending req1 waits for it to fall
        hold = 10; lat = 3;
        ack_log.delete();
        pend[0] = 1;
        wait_go(20, "t5_go");
        pend[1] = 1;
        run_acks(2, 200, "t5_acks");
        chk("t5_nacks", ack_log.size(), 2);
        chk("t5_second", (ack_log.size() > 1) ? ack_log[1] : -1, 1);
        chk("t5_gap", last_gap, 3);
        hold = 0; lat = 2;
        for (int i = 0; i < 4; i++) step();

        // reset while waiting on the unit
        stuck = 1;
        pend[0] = 1;
        wait_go(20, "t6_go");
        for (int i = 0; i < 3; i++) step();
        do_reset(1);
        stuck = 0;
        ack_log.delete();
        fop[0] = 0; fa[0] = 12; fb[0] = 12;
        pend[0] = 1; pend[1] = 1;
        run_acks(2, 100, "t6_acks");
        chk("t6_first", (ack_log.size() > 0) ? ack_log[0] : -1, 0);

        // randomized traffic
        do_reset(0);
        rand_ops = 1; rand_unit = 1; raise_pct = 40;
        pend[0] = 30; pend[1] = 30;
        run_acks(60, 5000, "t7_acks");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/arbitro_mult_div.md
Name: arbitro_mult_div

Overview:
Round-robin arbiter and sequencer that shares one multiplier/divisor unit between two requesters. It latches the winning requester's operands and operation, drives the unit's go/div_mult/ent_32/ent_16 inputs and waits for done. It then captures sal_32 and returns it with a one-cycle acknowledge. It sits between the requesters and the unit (the cascaron instance) and adds a watchdog timeout.

Parameters:
ANCHO_A, 32, width of 32-bit operand and result
ANCHO_B, 16, width of 16-bit operand
TMO_CICLOS, 200, max cycles in ESPERA without done before error (counter 8 bits)

Ports:
reloj  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  requester 0 request, held until ack0
op0  input  1  requester 0 operation, 1=divide 0=multiply (div_mult encoding)
a0  input  ANCHO_A  requester 0 32-bit operand
b0  input  ANCHO_B  requester 0 16-bit operand
req1, op1, a1, b1  input  1/1/ANCHO_A/ANCHO_B  same for requester 1
ack0  output  1  one-cycle completion pulse to requester 0
ack1  output  1  one-cycle completion pulse to requester 1
res  output  ANCHO_A  result, valid while ack0 or ack1 high
err  output  1  high with ack when the operation timed out
go  output  1  start to unit
div_mult  output  1  operation to unit
ent_32  output  ANCHO_A  operand to unit
ent_16  output  ANCHO_B  operand to unit
sal_32  input  ANCHO_A  unit result
done  input  1  unit completion

Behaviour:
- Reset (reset=0, asynchronous): state REPOSO; go, ack0, ack1, err, div_mult = 0; res, ent_32, ent_16 = 0; wd counter = 0; priority pointer = requester 0.
- All outputs are registered. No combinational paths from inputs to outputs.
- REPOSO:
  - If only one req is high, grant it.
  - If both are high, grant the one the pointer selects.
  - On the grant edge: latch op/a/b into div_mult/ent_32/ent_16, record grant id, go to LANZA.
  - If no req, stay.
- LANZA: go=1 for the cycle; clear wd counter; go to ESPERA.
- ESPERA:
  - go held 1; wd increments each cycle.
  - done sampled 1: res<=sal_32, err<=0, go to ENTREGA.
  - wd reaches TMO_CICLOS with done=0: res<=0, err<=1, go to ENTREGA.
  - done and timeout on the same edge: done wins.
- ENTREGA:
  - go=0. Exactly one of ack0/ack1 (the granted one) is high for one cycle.
  - res and err are valid during that cycle.
  - The pointer moves to the other requester.
  - Go to LIBERA.
- LIBERA:
  - go=0; ack low; res/err keep their value.
  - Stay while done=1. Go to REPOSO on the first edge with done=0; minimum one cycle.
- Requester rule: hold req and operands stable until ack. Drop req in the cycle after ack. req seen high in REPOSO is a new request. Operand changes after the grant edge are ignored.
- Latency: ack is high in the cycle after the edge where done is first sampled high. Minimum req-sampled-to-ack = 3 cycles plus unit latency.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1...
- A timed-out operation still passes through LIBERA. If the unit never drops done, the arbiter stays in LIBERA and issues no new grant. This is intentional; no override.
- Reset mid-operation: immediate return to the reset state. An in-flight request gets no ack. The requester must re-request after reset rises.

Test Plan:
- req0=1, op0=0, a0=1000, b0=25 -> go rises 2 cycles after req sampled; ack0 one cycle with res=25000, err=0; ack1 never high.
- req1=1, op1=1, a1=100000, b1=7 -> ack1 pulse; res equals mult_div_ideal output for the same inputs; err=0.
- req0 and req1 both raised right after reset, each re-raised immediately after its ack, for 4 operations -> grant order 0,1,0,1; each ack a single cycle; no overlap between ack0 and ack1.
- Unit model with done stuck 0 -> exactly TMO_CICLOS cycles in ESPERA, then the granted ack with err=1, res=0; next request served normally once done=0.
- Unit model holding done=1 for 10 cycles after completion -> ack once; stays in LIBERA; a pending req1 is granted only after done falls.
- reset pulled low during ESPERA -> go, ack and err drop to 0 asynchronously; after release, req1 and req0 together -> requester 0 granted first.
